// File: rtl/exec_unit.sv
// ALU command responder: single-cycle arithmetic/logic/shift ops plus an
// iterative restoring divider, reporting completion with a one-cycle done pulse.
module exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [7:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             z,
  output logic             c,
  output logic             done,
  output logic             busy,
  output logic             illegal,
  output logic             dbg_state
);
  localparam int SHW = $clog2(WIDTH);

  // Handshake: a command is accepted when start=1 at a rising edge while busy=0;
  // each accepted command produces exactly one done pulse, and starts seen
  // while busy=1 are dropped without any side effect.
  typedef enum logic {S_IDLE = 1'b0, S_DIV = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;

  logic             w_div_go;
  logic             w_last;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;

  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_legal;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [SHW-1:0]     w_n;

  assign busy      = (r_state == S_DIV);
  assign dbg_state = r_state;

  assign w_div_go = (r_state == S_IDLE) && start && (alu_op == 8'h04) && (b != '0);
  assign w_last   = (r_state == S_DIV) && (r_cnt == SHW'(WIDTH - 1));

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_trial  = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
  assign w_qbit   = ~w_trial[WIDTH];
  assign w_rem_nx = w_qbit ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_quo_nx = {r_quo[WIDTH-2:0], w_qbit};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_div_go) w_next = S_DIV;
      S_DIV:   if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Shift carries fall out of a one-bit-wider shifter: bit WIDTH for left,
  // bit 0 for right, both naturally zero when the amount is zero.
  always_comb begin
    w_n     = b[SHW-1:0];
    w_sum   = {1'b0, a} + {1'b0, b};
    w_prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    w_shl   = {1'b0, a} << w_n;
    w_shr   = {a, 1'b0} >> w_n;
    w_res   = '0;
    w_c     = 1'b0;
    w_legal = 1'b1;
    case (alu_op)
      8'h01: begin w_res = w_sum[WIDTH-1:0]; w_c = w_sum[WIDTH]; end
      8'h02: begin w_res = a - b; w_c = (a < b); end
      8'h03: begin w_res = w_prod[WIDTH-1:0]; w_c = |w_prod[2*WIDTH-1:WIDTH]; end
      8'h04: begin w_res = '1; w_c = 1'b1; end
      8'h05: w_res = ~a;
      8'h06: w_res = a | b;
      8'h07: w_res = a ^ b;
      8'h08: w_res = a & b;
      8'h09: begin w_res = w_shl[WIDTH-1:0]; w_c = w_shl[WIDTH]; end
      8'h0A: begin w_res = w_shr[WIDTH:1]; w_c = w_shr[0]; end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      result    <= '0;
      remainder <= '0;
      z         <= 1'b0;
      c         <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      r_cnt     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (r_state == S_IDLE && start) begin
        if (w_div_go) begin
          r_quo <= a;
          r_rem <= '0;
          r_dvs <= b;
          r_cnt <= '0;
        end else begin
          done <= 1'b1;
          if (!w_legal) begin
            illegal <= 1'b1;
          end else begin
            result <= w_res;
            z      <= (w_res == '0);
            c      <= w_c;
            // divide by zero reports the dividend as the remainder
            if (alu_op == 8'h04) remainder <= a;
          end
        end
      end else if (r_state == S_DIV) begin
        r_quo <= w_quo_nx;
        r_rem <= w_rem_nx;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          result    <= w_quo_nx;
          remainder <= w_rem_nx;
          z         <= (w_quo_nx == '0);
          c         <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// Directed plus randomized checks of exec_unit against an arithmetic reference
// model that tracks the architecturally visible result/remainder/flags.
module tb_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   alu_op = 8'h00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result, remainder;
  logic         z, c, done, busy, illegal, dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_rem = '0;
  logic         m_z = 1'b0;
  logic         m_c = 1'b0;

  always #5 clk = ~clk;

  exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .alu_op(alu_op), .a(a), .b(b),
    .result(result), .remainder(remainder), .z(z), .c(c), .done(done),
    .busy(busy), .illegal(illegal), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on wide integers.
  task automatic model(input logic [7:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic legal, output logic multi);
    logic [63:0]  wide;
    logic [W-1:0] r;
    logic         cy;
    int           n;
    legal = 1'b1;
    multi = 1'b0;
    r     = '0;
    cy    = 1'b0;
    n     = int'(bv % W);
    case (op)
      8'h01: begin wide = 64'(av) + 64'(bv); r = wide[W-1:0]; cy = wide[W]; end
      8'h02: begin r = av - bv; cy = (av < bv); end
      8'h03: begin wide = 64'(av) * 64'(bv); r = wide[W-1:0]; cy = (wide[63:32] != 0); end
      8'h04: begin
        if (bv == 0) begin r = '1; m_rem = av; cy = 1'b1; end
        else begin r = av / bv; m_rem = av % bv; multi = 1'b1; end
      end
      8'h05: r = ~av;
      8'h06: r = av | bv;
      8'h07: r = av ^ bv;
      8'h08: r = av & bv;
      8'h09: begin r = av << n; cy = (n > 0) ? av[W-n] : 1'b0; end
      8'h0A: begin r = av >> n; cy = (n > 0) ? av[n-1] : 1'b0; end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      m_res = r;
      m_c   = cy;
      m_z   = (r == 0);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_result"}, result, m_res);
    chk({tag, "_rem"}, remainder, m_rem);
    chk({tag, "_z"}, W'(z), W'(m_z));
    chk({tag, "_c"}, W'(c), W'(m_c));
  endtask

  task automatic do_op(input string tag, input logic [7:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv);
    logic legal, multi;
    int   k;
    @(negedge clk);
    start = 1'b1; alu_op = op; a = av; b = bv;
    model(op, av, bv, legal, multi);
    @(posedge clk); #1;
    start = 1'b0;
    if (multi) begin
      chk({tag, "_busy_E"}, W'(busy), 1);
      chk({tag, "_done_E"}, W'(done), 0);
      k = 0;
      while (!done && k < W + 8) begin
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1; alu_op = 8'($urandom_range(1, 10)); a = $urandom; b = $urandom;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        k++;
      end
      start = 1'b0;
      chk({tag, "_latency"}, W'(k), W);
      chk({tag, "_busy_end"}, W'(busy), 0);
    end else begin
      chk({tag, "_done"}, W'(done), 1);
      chk({tag, "_busy"}, W'(busy), 0);
    end
    chk({tag, "_illegal"}, W'(illegal), W'(!legal));
    check_outs(tag);
    @(posedge clk); #1;
    chk({tag, "_done_after"}, W'(done), 0);
    chk({tag, "_illegal_after"}, W'(illegal), 0);
    chk({tag, "_busy_after"}, W'(busy), 0);
  endtask

  initial begin
    logic legal, multi;
    logic [7:0] op;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset");
    chk("reset_done", W'(done), 0);
    chk("reset_busy", W'(busy), 0);
    chk("reset_illegal", W'(illegal), 0);
    rstn = 1'b1;

    do_op("add_wrap", 8'h01, 32'hFFFF_FFFF, 32'h0000_0001);
    do_op("sub_borrow", 8'h02, 32'd5, 32'd7);
    do_op("mul_ovf", 8'h03, 32'h0001_0000, 32'h0001_0000);

    // Divide 100/7 with operand changes and an ignored start mid-flight
    @(negedge clk);
    start = 1'b1; alu_op = 8'h04; a = 32'd100; b = 32'd7;
    model(8'h04, 32'd100, 32'd7, legal, multi);
    @(posedge clk); #1;
    start = 1'b0;
    chk("div7_busy_E", W'(busy), 1);
    for (int k = 1; k <= W; k++) begin
      if (k == 3) begin a = 32'h5555_0000; b = 32'd1; end
      if (k == 5) begin start = 1'b1; alu_op = 8'h01; end
      if (k == 6) start = 1'b0;
      @(posedge clk); #1;
      if (k < W) begin
        chk("div7_done_early", W'(done), 0);
        chk("div7_busy_mid", W'(busy), 1);
      end
    end
    chk("div7_done", W'(done), 1);
    chk("div7_busy_end", W'(busy), 0);
    chk("div7_q_lit", result, 32'd14);
    chk("div7_r_lit", remainder, 32'd2);
    check_outs("div7");
    @(posedge clk); #1;
    chk("div7_done_after", W'(done), 0);

    do_op("div_zero", 8'h04, 32'h0000_1234, 32'h0);
    do_op("lshift", 8'h09, 32'h8000_0001, 32'd1);
    do_op("rshift", 8'h0A, 32'h0000_0003, 32'h21);
    do_op("rshift0", 8'h0A, 32'hA5A5_0F0F, 32'h0);

    // Reset aborts an in-flight divide
    @(negedge clk);
    start = 1'b1; alu_op = 8'h04; a = 32'hFFFF_FFFF; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", W'(done), 0);
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    m_res = '0; m_rem = '0; m_z = 1'b0; m_c = 1'b0;
    check_outs("abort");
    chk("abort_busy", W'(busy), 0);
    chk("abort_done", W'(done), 0);
    do_op("illegal_81", 8'h81, 32'h1111_1111, 32'h2222_2222);

    // Randomized commands, including illegal codes and zero/small divisors
    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [W-1:0] av, bv;
      sel = $urandom_range(0, 11);
      op  = (sel == 11) ? 8'($urandom) : 8'(sel);
      av  = $urandom;
      bv  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      do_op("rand", op, av, bv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
